// File: rtl/uart_rx_pkg.sv
// Shared types and MMIO constants for the UART receive path.
// The status word packs tx/rx state for the 0x80000008 register.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

    localparam logic [31:0] UART_STATUS_ADDR  = 32'h8000_0008;
    localparam logic [31:0] UART_RX_DATA_ADDR = 32'h8000_000C;

    localparam int UART_STAT_TX_BUSY   = 0;
    localparam int UART_STAT_RX_VALID  = 1;
    localparam int UART_STAT_FRAME_ERR = 2;
    localparam int UART_STAT_OVERRUN   = 3;

    function automatic logic [31:0] uart_status_word(
        input logic tx_busy,
        input logic rx_valid,
        input logic frame_err,
        input logic overrun
    );
        logic [31:0] w;
        w = '0;
        w[UART_STAT_TX_BUSY]   = tx_busy;
        w[UART_STAT_RX_VALID]  = rx_valid;
        w[UART_STAT_FRAME_ERR] = frame_err;
        w[UART_STAT_OVERRUN]   = overrun;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Show-ahead synchronous FIFO; rdata is the head read from registered storage.
// A push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Gate the head so the output reads zero whenever nothing is queued.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM,
// show-ahead receive FIFO and sticky framing/overrun flags.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            rx,
    input  logic                            rd_en,
    input  logic                            err_clr,
    output logic [7:0]                      rx_data,
    output logic                            rx_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            rx_busy,
    output logic                            frame_err,
    output logic                            overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

    logic           rx_meta_q, rx_meta_d;
    logic           rx_sync_q, rx_sync_d;
    uart_rx_state_t state_q;
    logic [CW-1:0]  clk_cnt_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     shift_q;
    logic           push_q;
    logic           ferr_set_q;
    logic           busy_q;
    logic           frame_err_q, frame_err_d;
    logic           overrun_q, overrun_d;
    logic           fifo_empty, fifo_full;

    always_comb begin
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
        end
    end

    // Receive FSM; push and framing-error events are registered one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
            busy_q     <= (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    clk_cnt_q <= '0;
                    if (!rx_sync_q) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (clk_cnt_q == CNT_HALF) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_sync_q ? IDLE : DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt_q == CNT_LAST) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt_q == CNT_LAST) begin
                        clk_cnt_q <= '0;
                        if (rx_sync_q) begin
                            push_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            ferr_set_q <= 1'b1;
                            state_q    <= WAIT_IDLE;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (rx_sync_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A push into a full FIFO is only lost when no pop frees a slot that cycle.
    always_comb begin
        frame_err_d = ferr_set_q | (frame_err_q & ~err_clr);
        overrun_d   = (push_q & fifo_full & ~rd_en) | (overrun_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .pop   (rd_en),
        .wdata (shift_q),
        .rdata (rx_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign rx_valid  = ~fifo_empty;
    assign rx_busy   = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial frames in, FIFO contents and flags out.
module tb_uart_rx;

    localparam int N     = 87;
    localparam int DEPTH = 4;
    localparam int H     = (N - 1) / 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    uart_rx #(
        .CLKS_PER_BIT (N),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rd_en      (rd_en),
        .err_clr    (err_clr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .fifo_count (fifo_count),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         t0 = 0;
    int         chk = 0;
    int         pass = 0;
    int         valid_rise = -1;
    int         busy_rise = -1;
    int         busy_fall = -1;
    logic       valid_prev = 1'b0;
    logic       busy_prev = 1'b0;
    logic [7:0] sb[$];
    logic [7:0] exp;
    logic       exp_ferr = 1'b0;
    logic       exp_ovr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Edge timestamps of rx_valid / rx_busy, taken on the falling edge.
    always @(negedge clk) begin
        if (rx_valid && !valid_prev) valid_rise = cyc;
        if (rx_busy && !busy_prev) busy_rise = cyc;
        if (!rx_busy && busy_prev) busy_fall = cyc;
        valid_prev = rx_valid;
        busy_prev  = rx_busy;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drives one 8N1 frame starting at a falling edge; updates the model.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) begin
            if (sb.size() < DEPTH) sb.push_back(b);
            else exp_ovr = 1'b1;
        end else begin
            exp_ferr = 1'b1;
        end
        t0 = cyc + 1;
        rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (N) @(negedge clk);
        end
        rx = stop_bit;
        repeat (N) @(negedge clk);
    endtask

    task automatic pop_pulse();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else pass++;
        chk++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else pass++;
        chk++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_data); else pass++;
        chk++; if (rx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", rx_busy); else pass++;
        chk++; if ({frame_err, overrun} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {frame_err, overrun}); else pass++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        valid_rise = -1; busy_rise = -1; busy_fall = -1;
        send_byte(8'hA5, 1'b1);
        chk++; if (valid_rise - t0 !== 830) $display("FAIL basic_latency: got %0d want 830", valid_rise - t0); else pass++;
        chk++; if (busy_rise - t0 !== 3) $display("FAIL basic_busy_rise: got %0d want 3", busy_rise - t0); else pass++;
        chk++; if (busy_fall - t0 !== 830) $display("FAIL basic_busy_fall: got %0d want 830", busy_fall - t0); else pass++;
        chk++; if (fifo_count !== 3'd1) $display("FAIL basic_count: got %0d want 1", fifo_count); else pass++;
        chk++; if (frame_err !== exp_ferr) $display("FAIL basic_ferr: got %b want %b", frame_err, exp_ferr); else pass++;
        exp = sb.pop_front();
        chk++; if (rx_valid !== 1'b1 || rx_data !== exp) $display("FAIL basic_data: got %b/%h want 1/%h", rx_valid, rx_data, exp); else pass++;
        pop_pulse();
        chk++; if (rx_valid !== 1'b0) $display("FAIL basic_pop_empty: got %b want 0", rx_valid); else pass++;
    endtask

    task automatic test_glitch();
        busy_rise = -1; busy_fall = -1;
        t0 = cyc + 1;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        chk++; if (busy_rise - t0 !== 3) $display("FAIL glitch_busy_rise: got %0d want 3", busy_rise - t0); else pass++;
        chk++; if (busy_fall - t0 !== 3 + H + 1) $display("FAIL glitch_busy_fall: got %0d want %0d", busy_fall - t0, 3 + H + 1); else pass++;
        chk++; if (fifo_count !== 3'd0) $display("FAIL glitch_count: got %0d want 0", fifo_count); else pass++;
        chk++; if ({frame_err, overrun} !== {exp_ferr, exp_ovr}) $display("FAIL glitch_flags: got %b want %b", {frame_err, overrun}, {exp_ferr, exp_ovr}); else pass++;
    endtask

    task automatic test_frame_err();
        send_byte(8'h3C, 1'b0);
        repeat (3 * N) @(negedge clk);
        chk++; if (fifo_count !== 3'd0) $display("FAIL ferr_no_push: got %0d want 0", fifo_count); else pass++;
        chk++; if (frame_err !== exp_ferr) $display("FAIL ferr_flag: got %b want %b", frame_err, exp_ferr); else pass++;
        chk++; if (rx_busy !== 1'b1) $display("FAIL ferr_wait_idle: got busy %b want 1", rx_busy); else pass++;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        chk++; if (rx_busy !== 1'b0) $display("FAIL ferr_back_idle: got busy %b want 0", rx_busy); else pass++;
        send_byte(8'h55, 1'b1);
        exp = sb.pop_front();
        chk++; if (rx_valid !== 1'b1 || rx_data !== exp) $display("FAIL ferr_next_data: got %b/%h want 1/%h", rx_valid, rx_data, exp); else pass++;
        pop_pulse();
        clr_pulse();
        exp_ferr = 1'b0;
        chk++; if (frame_err !== exp_ferr) $display("FAIL ferr_clear: got %b want %b", frame_err, exp_ferr); else pass++;
    endtask

    task automatic test_overrun();
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1);
        chk++; if (fifo_count !== 3'(sb.size())) $display("FAIL ovr_count: got %0d want %0d", fifo_count, sb.size()); else pass++;
        chk++; if (overrun !== exp_ovr) $display("FAIL ovr_flag: got %b want %b", overrun, exp_ovr); else pass++;
        for (int i = 0; i < DEPTH; i++) begin
            exp = sb.pop_front();
            chk++; if (rx_valid !== 1'b1 || rx_data !== exp) $display("FAIL ovr_pop%0d: got %b/%h want 1/%h", i, rx_valid, rx_data, exp); else pass++;
            pop_pulse();
        end
        chk++; if (rx_valid !== 1'b0) $display("FAIL ovr_drained: got %b want 0", rx_valid); else pass++;
        clr_pulse();
        exp_ovr = 1'b0;
        chk++; if (overrun !== exp_ovr) $display("FAIL ovr_clear: got %b want %b", overrun, exp_ovr); else pass++;
    endtask

    task automatic test_push_pop_full();
        int tp;
        logic [7:0] head;
        for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b1);
        chk++; if (fifo_count !== 3'd4) $display("FAIL pp_full_count: got %0d want 4", fifo_count); else pass++;
        head = sb.pop_front();
        tp = cyc + 1;
        fork
            send_byte(8'h05, 1'b1);
            begin
                while (cyc != tp + 829) @(negedge clk);
                chk++; if (rx_data !== head) $display("FAIL pp_head: got %h want %h", rx_data, head); else pass++;
                pop_pulse();
            end
        join
        chk++; if (overrun !== exp_ovr) $display("FAIL pp_overrun: got %b want %b", overrun, exp_ovr); else pass++;
        chk++; if (fifo_count !== 3'(sb.size())) $display("FAIL pp_count: got %0d want %0d", fifo_count, sb.size()); else pass++;
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            chk++; if (rx_valid !== 1'b1 || rx_data !== exp) $display("FAIL pp_pop: got %b/%h want 1/%h", rx_valid, rx_data, exp); else pass++;
            pop_pulse();
        end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'h42, 1'b1);
        rx = 1'b0;
        repeat (N) @(negedge clk);
        rx = 1'b1;
        repeat (2 * N) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk++; if (rx_valid !== 1'b0 || fifo_count !== 3'd0) $display("FAIL rst_mid_fifo: got %b/%0d want 0/0", rx_valid, fifo_count); else pass++;
        chk++; if (rx_busy !== 1'b0 || rx_data !== 8'h00) $display("FAIL rst_mid_busy_data: got %b/%h want 0/00", rx_busy, rx_data); else pass++;
        chk++; if ({frame_err, overrun} !== 2'b00) $display("FAIL rst_mid_flags: got %b want 00", {frame_err, overrun}); else pass++;
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_byte(8'h81, 1'b1);
        chk++; if (fifo_count !== 3'd1) $display("FAIL rst_mid_count: got %0d want 1", fifo_count); else pass++;
        exp = sb.pop_front();
        chk++; if (rx_valid !== 1'b1 || rx_data !== exp) $display("FAIL rst_mid_data: got %b/%h want 1/%h", rx_valid, rx_data, exp); else pass++;
        pop_pulse();
        chk++; if ({frame_err, overrun} !== {exp_ferr, exp_ovr}) $display("FAIL rst_mid_after_flags: got %b want %b", {frame_err, overrun}, {exp_ferr, exp_ovr}); else pass++;
    endtask

    initial begin
        rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_push_pop_full();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver, the receive-side counterpart of the existing uart_tx on the MMIO bus. It synchronises the serial rx pin, validates the start bit at mid-bit, and samples 8 data bits LSB-first plus the stop bit. Accepted bytes go into a small show-ahead FIFO that the data-memory MMIO decoder pops. Sticky framing-error and overrun flags are exposed for the status register.

Parameters:
CLKS_PER_BIT, 87, clock cycles per bit (N); must be >= 4; half-bit point H = (N-1)/2 (integer)
FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
rd_en  input  1  pop FIFO head this cycle; ignored when empty
err_clr  input  1  clear frame_err and overrun
rx_data  output  8  FIFO head byte; valid only when rx_valid=1
rx_valid  output  1  FIFO not empty
fifo_count  output  $clog2(FIFO_DEPTH+1)  occupied entries
rx_busy  output  1  frame in progress (state != IDLE)
frame_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: byte completed while FIFO full

Behaviour:
- Reset (async assert, sync release): state=IDLE, all counters 0, FIFO empty, rx_valid=0, fifo_count=0, rx_data=0, frame_err=0, overrun=0, rx_busy=0. Both synchroniser flops reset to 1.
- Synchroniser: 2 flops, rx -> rx_sync. The FSM uses only rx_sync.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on rx_sync=0 -> START, clk_cnt=0.
- START: clk_cnt increments each cycle. At clk_cnt==H: if rx_sync=0 -> DATA, clk_cnt=0, bit_idx=0; otherwise false start -> IDLE with no flag.
- DATA: at clk_cnt==N-1, shift rx_sync in at the MSB of the shift register (LSB-first line order), clk_cnt=0, bit_idx++. After bit_idx 7 is sampled -> STOP.
- STOP: at clk_cnt==N-1, sample rx_sync.
  - 1: push byte -> IDLE.
  - 0: discard byte, set frame_err -> WAIT_IDLE.
- WAIT_IDLE: stay until rx_sync=1, then -> IDLE. Break conditions therefore never produce repeated frames.
- Latency: pin falling edge first sampled by clk at cycle t0. rx_valid (on an empty FIFO) rises at t0+4+H+9N exactly (N=87: t0+830). rx_busy is high from t0+3 through the push cycle.
- FIFO: show-ahead, so rx_data = head combinationally from registered storage. Pointers wrap modulo FIFO_DEPTH.
  - rd_en with rx_valid: head advances next cycle.
  - Push when full: byte dropped, overrun set, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both occur, no overrun, count unchanged.
  - Push and pop in the same cycle while non-full: count unchanged.
- Sticky flags: set only by the events above, cleared by err_clr. Set and err_clr in the same cycle: set wins.
- Reset mid-frame: partial byte lost, FIFO flushed. If rx is low at reset release, it is treated as a start edge and validated at mid-bit as usual.
- Width rules: clk_cnt width $clog2(N); bit_idx 3 bits; fifo_count saturates at FIFO_DEPTH by construction.

Decomposition:
- riscv_pkg additions:
  - uart_rx_state_t enum (IDLE, START, DATA, STOP, WAIT_IDLE)
  - UART_RX_DATA_ADDR = 32'h8000000C (read pops)
  - status bit positions for the existing 0x80000008 status word: bit0 tx_busy, bit1 rx_valid, bit2 frame_err, bit3 overrun
- Sub-module sync_fifo (params WIDTH, DEPTH; ports clk, rst_n, push, pop, wdata, rdata, empty, full, count). It is reused later for TX buffering.

Test Plan:
- Send 0xA5 at N=87, start edge at t0 -> rx_valid rises at t0+830, rx_data=0xA5, fifo_count=1, frame_err=0. Pulse rd_en -> rx_valid=0 next cycle.
- rx low for 20 cycles then high (glitch shorter than H) -> FSM returns to IDLE, no push, no flags, rx_busy drops at t0+3+H+1.
- Send 0x3C with stop bit forced 0, then hold the line low for 3N -> no push, frame_err=1, state stays WAIT_IDLE until rx high. A following 0x55 is received correctly. err_clr -> frame_err=0.
- Send 5 bytes 0x01..0x05 with no reads (DEPTH 4) -> fifo_count=4, overrun=1, pops return 0x01,0x02,0x03,0x04.
- FIFO full, assert rd_en in the exact push cycle of the 5th byte -> overrun=0, count stays 4, pop order 0x02..0x05.
- Deassert rst_n mid-DATA of 0xFF -> all outputs at reset values immediately. After release with rx high, a fresh 0x81 is received with no residue.
